// File: rtl/iter_shifter.sv
// Iterative shifter: SLL / SRL / SRA / pass-through, at most two bit positions per cycle.
// Optional feature macro: ITER_SHIFTER_SRA_EN (op 10 sign-fills; otherwise it zero-fills like SRL).
module iter_shifter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   in,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   out
);

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_PASS = 2'b11;
`ifdef ITER_SHIFTER_SRA_EN
    localparam logic [1:0] OP_SRA  = 2'b10;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               left_q, left_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
`ifdef ITER_SHIFTER_SRA_EN
    logic               sfill_q, sfill_d;
`endif

    logic               two_step;
    logic [SHAMT_W-1:0] step;
    logic [SHAMT_W-1:0] cnt_next;
    logic               fill;
    logic [WIDTH-1:0]   shifted;

    // One iteration of the working register: shift by 1 or 2 in the captured direction.
    always_comb begin
        two_step = (cnt_q >= SHAMT_W'(2));
        step     = two_step ? SHAMT_W'(2) : SHAMT_W'(1);
        cnt_next = cnt_q - step;
`ifdef ITER_SHIFTER_SRA_EN
        fill     = sfill_q;
`else
        fill     = 1'b0;
`endif
        if (left_q) begin
            shifted = two_step ? {work_q[WIDTH-3:0], 2'b00} : {work_q[WIDTH-2:0], 1'b0};
        end else begin
            shifted = two_step ? {fill, fill, work_q[WIDTH-1:2]} : {fill, work_q[WIDTH-1:1]};
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        out_d   = out_q;
        done_d  = 1'b0;
`ifdef ITER_SHIFTER_SRA_EN
        sfill_d = sfill_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    work_d = in;
                    cnt_d  = shamt;
                    left_d = (op == OP_SLL);
`ifdef ITER_SHIFTER_SRA_EN
                    sfill_d = (op == OP_SRA) && in[WIDTH-1];
`endif
                    if ((shamt != '0) && (op != OP_PASS)) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                        out_d   = in;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                work_d = shifted;
                cnt_d  = cnt_next;
                if (cnt_next == '0) begin
                    state_d = ST_DONE;
                    out_d   = shifted;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            out_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef ITER_SHIFTER_SRA_EN
            sfill_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            out_q   <= out_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef ITER_SHIFTER_SRA_EN
            sfill_q <= sfill_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed self-checking bench for iter_shifter.
module tb_iter_shifter;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [4:0]  shamt;
    logic [31:0] din;
    logic        busy;
    logic        done;
    logic [31:0] out;

    int n_cmp = 0;
    int n_err = 0;

    iter_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .shamt (shamt),
        .in    (din),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // Issue one operation and check latency, result, busy and out stability.
    task automatic run_op(input string tag, input logic [1:0] o, input int s,
                          input logic [31:0] d, input logic [31:0] exp_out, input int exp_lat);
        int          n;
        logic        ok_busy;
        logic        ok_hold;
        logic [31:0] prev;
        prev    = out;
        op      = o;
        shamt   = 5'(s);
        din     = d;
        start   = 1'b1;
        n       = 0;
        ok_busy = 1'b1;
        ok_hold = 1'b1;
        do begin
            tick();
            start = 1'b0;
            din   = $urandom;
            shamt = 5'($urandom_range(0, 31));
            op    = 2'($urandom_range(0, 3));
            n++;
            if (!done) begin
                if (busy !== 1'b1) ok_busy = 1'b0;
                if (out !== prev) ok_hold = 1'b0;
            end
        end while (!done && n < 40);
        chk({tag, " latency"}, 32'(n), 32'(exp_lat));
        chk({tag, " out"}, out, exp_out);
        chk({tag, " busy in done"}, 32'(busy), 32'd1);
        chk({tag, " busy while shifting"}, 32'(ok_busy), 32'd1);
        chk({tag, " out held while shifting"}, 32'(ok_hold), 32'd1);
        tick();
        chk({tag, " done single pulse"}, 32'(done), 32'd0);
        chk({tag, " busy after done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int          pulses;
        int          lat;
        logic [31:0] res;
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        shamt = 5'd0;
        din   = 32'h0;
        tick();
        tick();
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset out", out, 32'h0);
        reset = 1'b0;
        tick();

        run_op("sll a<<2", 2'b00, 2, 32'h0000000A, 32'h00000028, 2);
        run_op("sll f<<2", 2'b00, 2, 32'hFFFFFFFF, 32'hFFFFFFFC, 2);
`ifdef ITER_SHIFTER_SRA_EN
        run_op("sra 31", 2'b10, 31, 32'h80000000, 32'hFFFFFFFF, 17);
        run_op("sra 4", 2'b10, 4, 32'h80000000, 32'hF8000000, 3);
`else
        run_op("sra 31", 2'b10, 31, 32'h80000000, 32'h00000001, 17);
        run_op("sra 4", 2'b10, 4, 32'h80000000, 32'h08000000, 3);
`endif
        run_op("srl 0", 2'b01, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
        run_op("pass", 2'b11, 7, 32'h12345678, 32'h12345678, 1);
        run_op("srl 1", 2'b01, 1, 32'h80000000, 32'h40000000, 2);
        run_op("sll 31", 2'b00, 31, 32'h00000001, 32'h80000000, 17);
        run_op("sll 3", 2'b00, 3, 32'hFFFFFFFF, 32'hFFFFFFF8, 3);
        run_op("srl 9", 2'b01, 9, 32'h0000FF00, 32'h0000007F, 6);

        // Second start one cycle into a busy operation must be dropped.
        op = 2'b00; shamt = 5'd5; din = 32'h00000001; start = 1'b1;
        tick();
        din = 32'h000000FF; shamt = 5'd1;
        tick();
        start = 1'b0;
        pulses = 0; lat = 0; res = 32'h0;
        for (int i = 2; i <= 12; i++) begin
            if (done) begin
                pulses++;
                lat = i;
                res = out;
            end
            tick();
        end
        chk("busy start pulses", 32'(pulses), 32'd1);
        chk("busy start latency", 32'(lat), 32'd4);
        chk("busy start out", res, 32'h00000020);

        // Start held during the DONE cycle must be ignored.
        op = 2'b01; shamt = 5'd2; din = 32'h00000100; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("done-cycle setup", 32'(done), 32'd1);
        start = 1'b1; din = 32'hDEADBEEF; shamt = 5'd0; op = 2'b11;
        tick();
        start = 1'b0;
        chk("start in done ignored busy", 32'(busy), 32'd0);
        chk("start in done ignored out", out, 32'h00000040);
        tick();
        chk("start in done no pulse", 32'(done), 32'd0);

        // Idle with start low holds out.
        for (int i = 0; i < 3; i++) begin
            din = $urandom;
            tick();
        end
        chk("idle hold out", out, 32'h00000040);

        // Reset aborts an in-flight operation.
        op = 2'b01; shamt = 5'd9; din = 32'hF0000000; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort out", out, 32'h0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) pulses++;
            tick();
        end
        chk("abort no activity", 32'(pulses), 32'd0);
        run_op("srl after abort", 2'b01, 9, 32'hF0000000, 32'h00780000, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
